// File: rtl/ultrasonic_ranger_multi.sv
// rtl/ultrasonic_ranger_multi.sv - round-robin multi-channel echo ranger with per-channel cm result, timeout and hysteretic object flag
module ultrasonic_ranger_multi #(
    parameter int NUM_CH         = 4,
    parameter int DIST_W         = 9,
    parameter int CYCLES_PER_CM  = 2915,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GAP_CYCLES     = 3000000,
    parameter int THRESH_CM      = 10,
    parameter int HYST_CM        = 2,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        echo_i,
    output logic [NUM_CH-1:0]        trigger_o,
    output logic [NUM_CH*DIST_W-1:0] dist_o,
    output logic                     dist_valid_o,
    output logic [CH_W-1:0]          dist_ch_o,
    output logic [NUM_CH-1:0]        timeout_o,
    output logic [NUM_CH-1:0]        object_detected_o,
    output logic                     busy_o
);

    localparam int MAX_A = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int MAX_C = (MAX_A > TRIG_CYCLES) ? MAX_A : TRIG_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [31:0]       SET_CM    = 32'(THRESH_CM);
    localparam logic [31:0]       CLR_CM    = 32'(THRESH_CM + HYST_CM);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, RESULT, GAP} state_t;

    state_t                    state_q;
    logic [CH_W-1:0]           ch_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [SUB_W-1:0]          sub_q;
    logic [DIST_W-1:0]         cm_q;
    logic                      prev_q;
    logic [NUM_CH-1:0]         sync1_q, sync2_q;
    logic [NUM_CH-1:0]         trig_q;
    logic [NUM_CH*DIST_W-1:0]  dist_q;
    logic                      valid_q;
    logic [CH_W-1:0]           dist_ch_q;
    logic [NUM_CH-1:0]         to_q;
    logic [NUM_CH-1:0]         obj_q;

    logic echo_s, rise, post_norm, post_to;

    always_comb begin
        echo_s    = sync2_q[ch_q];
        rise      = 1'b0;
        post_norm = 1'b0;
        post_to   = 1'b0;
        if (state_q == WAIT_RISE) begin
            rise    = echo_s && !prev_q;
            post_to = !rise && (cnt_q == TO_LAST);
        end else if (state_q == MEASURE) begin
            post_norm = !echo_s;
            post_to   = echo_s && (cnt_q == TO_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            prev_q    <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            trig_q    <= '0;
            dist_q    <= '0;
            valid_q   <= 1'b0;
            dist_ch_q <= '0;
            to_q      <= '0;
            obj_q     <= '0;
        end else begin
            sync1_q <= echo_i;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q      <= TRIG;
                        trig_q[ch_q] <= 1'b1;
                        cnt_q        <= '0;
                    end
                end
                TRIG: begin
                    if (cnt_q == TRIG_LAST) begin
                        trig_q  <= '0;
                        cnt_q   <= '0;
                        // an echo already high on entry must drop before it can count as a rise
                        prev_q  <= 1'b1;
                        state_q <= WAIT_RISE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_RISE: begin
                    prev_q <= echo_s;
                    if (rise) begin
                        // the rise cycle is itself the first high cycle of the pulse
                        state_q <= MEASURE;
                        cnt_q   <= '0;
                        sub_q   <= (SUB_LAST == '0) ? '0 : SUB_W'(1);
                        cm_q    <= (SUB_LAST == '0) ? DIST_W'(1) : '0;
                    end else if (!post_to) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MEASURE: begin
                    if (echo_s && !post_to) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (sub_q == SUB_LAST) begin
                            sub_q <= '0;
                            if (cm_q != '1) cm_q <= cm_q + 1'b1;
                        end else begin
                            sub_q <= sub_q + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    state_q <= GAP;
                    cnt_q   <= '0;
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        ch_q    <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (post_norm || post_to) begin
                state_q   <= RESULT;
                valid_q   <= 1'b1;
                dist_ch_q <= ch_q;
                to_q[ch_q] <= post_to;
                if (post_to) begin
                    dist_q[ch_q*DIST_W +: DIST_W] <= '1;
                    obj_q[ch_q]                   <= 1'b0;
                end else begin
                    dist_q[ch_q*DIST_W +: DIST_W] <= cm_q;
                    if (32'(cm_q) <= SET_CM)
                        obj_q[ch_q] <= 1'b1;
                    else if (32'(cm_q) > CLR_CM)
                        obj_q[ch_q] <= 1'b0;
                end
            end
        end
    end

    assign trigger_o         = trig_q;
    assign dist_o            = dist_q;
    assign dist_valid_o      = valid_q;
    assign dist_ch_o         = dist_ch_q;
    assign timeout_o         = to_q;
    assign object_detected_o = obj_q;
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger_multi.sv
// tb/tb_ultrasonic_ranger_multi.sv - scoreboard bench for the two-channel ranger with small timing parameters
module tb_ultrasonic_ranger_multi;

    localparam int NC = 2;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [NC-1:0] echo_i = '0;
    logic [NC-1:0] trigger_o;
    logic [NC*DW-1:0] dist_o;
    logic          dist_valid_o;
    logic [0:0]    dist_ch_o;
    logic [NC-1:0] timeout_o;
    logic [NC-1:0] object_detected_o;
    logic          busy_o;

    ultrasonic_ranger_multi #(
        .NUM_CH(NC), .DIST_W(DW), .CYCLES_PER_CM(4), .TRIG_CYCLES(3),
        .TIMEOUT_CYCLES(400), .GAP_CYCLES(10), .THRESH_CM(10), .HYST_CM(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .echo_i(echo_i),
        .trigger_o(trigger_o), .dist_o(dist_o), .dist_valid_o(dist_valid_o),
        .dist_ch_o(dist_ch_o), .timeout_o(timeout_o),
        .object_detected_o(object_detected_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic       ch;
        logic [5:0] d;
        logic       t;
        logic       o;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [5:0] m_dist[NC];
    logic       m_to[NC];
    logic       m_obj[NC];
    int         trig_seq[$];
    bit         multi_trig = 1'b0;
    int         min_gap = 1000000;
    int         last_v = 0;
    bit         seen_v = 1'b0;
    logic       prev_valid = 1'b0;
    logic [NC-1:0] prev_trig = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NC; k++) begin
            m_dist[k] = '0;
            m_to[k]   = 1'b0;
            m_obj[k]  = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_trig"},  64'(trigger_o), 64'd0);
        chk({tag, "_dist"},  64'(dist_o), 64'd0);
        chk({tag, "_valid"}, 64'(dist_valid_o), 64'd0);
        chk({tag, "_ch"},    64'(dist_ch_o), 64'd0);
        chk({tag, "_to"},    64'(timeout_o), 64'd0);
        chk({tag, "_obj"},   64'(object_detected_o), 64'd0);
        chk({tag, "_busy"},  64'(busy_o), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_trig(input int ch);
        int n = 0;
        while (!trigger_o[ch] && n < 3000) begin
            step();
            n++;
        end
        chk("trig_seen", 64'(trigger_o[ch]), 64'd1);
    endtask

    task automatic run_meas(input int ch, input int hi, input bit pre, input bit noise,
                            input bit drop_en, input logic [5:0] d, input bit t, input bit o);
        exp_t e;
        int   w = 0;
        e.ch = ch[0];
        e.d  = d;
        e.t  = t;
        e.o  = o;
        sb.push_back(e);
        wait_trig(ch);
        if (pre) echo_i[ch] = 1'b1;
        while (trigger_o[ch] && w < 100) begin
            step();
            w++;
        end
        chk("trig_width", 64'(w), 64'd3);
        if (drop_en) enable = 1'b0;
        if (pre) begin
            repeat (4) step();
            echo_i[ch] = 1'b0;
            repeat (4) step();
        end else begin
            repeat (3) step();
        end
        if (hi > 0) begin
            echo_i[ch] = 1'b1;
            if (noise) echo_i[1-ch] = 1'b1;
            repeat (hi) step();
            echo_i = '0;
        end
        drain();
        if (drop_en) begin
            repeat (20) step();
            chk("halt_busy", 64'(busy_o), 64'd0);
            chk("halt_trig", 64'(trigger_o), 64'd0);
            enable = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones(trigger_o) > 1) multi_trig = 1'b1;
            for (int k = 0; k < NC; k++) begin
                if (trigger_o[k] && !prev_trig[k]) begin
                    trig_seq.push_back(k);
                    if (seen_v) begin
                        if (cyc - last_v < min_gap) min_gap = cyc - last_v;
                        seen_v = 1'b0;
                    end
                end
            end
            if (dist_valid_o) begin
                chk("valid_pulse", 64'(prev_valid), 64'd0);
                last_v = cyc;
                seen_v = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 64'(dist_valid_o), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    m_dist[e.ch] = e.d;
                    m_to[e.ch]   = e.t;
                    m_obj[e.ch]  = e.o;
                    chk("dist_ch", 64'(dist_ch_o), 64'(e.ch));
                    for (int k = 0; k < NC; k++) begin
                        chk($sformatf("dist%0d", k), 64'(dist_o[k*DW +: DW]), 64'(m_dist[k]));
                        chk($sformatf("to%0d", k),   64'(timeout_o[k]), 64'(m_to[k]));
                        chk($sformatf("obj%0d", k),  64'(object_detected_o[k]), 64'(m_obj[k]));
                    end
                end
            end
        end else begin
            seen_v = 1'b0;
        end
        prev_valid = dist_valid_o;
        prev_trig  = trigger_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
        clear_model();
        #1;
        chk_zero("rst");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("idle_busy", 64'(busy_o), 64'd0);
        enable = 1'b1;

        //        ch  hi  pre noise drop dist to obj
        run_meas(0,  40, 0,  0,    0,   6'd10, 0, 1);
        run_meas(1,  20, 0,  0,    0,   6'd5,  0, 1);
        run_meas(0,  48, 0,  0,    0,   6'd12, 0, 1);
        run_meas(1,   0, 0,  0,    0,   6'd63, 1, 0);
        run_meas(0,  52, 0,  0,    0,   6'd13, 0, 0);
        run_meas(1, 300, 0,  0,    0,   6'd63, 0, 0);
        run_meas(0, 500, 0,  0,    1,   6'd63, 1, 0);
        run_meas(1,  44, 0,  0,    0,   6'd11, 0, 0);
        run_meas(0,  42, 0,  1,    0,   6'd10, 0, 1);
        run_meas(1,  24, 1,  0,    0,   6'd6,  0, 1);

        // abort a ch0 measurement with reset while the echo is high
        wait_trig(0);
        while (trigger_o[0]) step();
        repeat (3) step();
        echo_i[0] = 1'b1;
        repeat (20) step();
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        echo_i = '0;
        clear_model();
        repeat (3) step();
        rst_n = 1'b1;
        run_meas(0, 40, 0, 0, 0, 6'd10, 0, 1);

        chk("one_hot_trig", 64'(multi_trig), 64'd0);
        chk("gap_ge_10", 64'(min_gap > 10), 64'd1);
        chk("trig_count", 64'(trig_seq.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < trig_seq.size())
                chk($sformatf("trig_order%0d", i), 64'(trig_seq[i]), 64'(exp_seq[i]));
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
